multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Execute-stage ALU directly downstream of the operand-B select mux.
- Consumes operand A from the register file, and operand B as either the register value or the zero-extended 16-bit immediate.
- Produces a registered 32-bit result plus zero flag.
- Simple ops finish in one cycle; shifts and multiply iterate, with a start/busy/done handshake so the control unit can stall.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- MUL_CYCLES, 32, iterations of the shift-add multiplier; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- opcode  input  4  operation select, sampled with start
- operandA  input  WIDTH  first operand, sampled with start
- operandB  input  WIDTH  second operand (operand-B mux output), sampled with start
- result  output  WIDTH  registered result; held until next completion
- zero  output  1  registered, 1 when result==0
- done  output  1  one-cycle pulse when result is updated
- busy  output  1  high while an iterative op is in progress
- illegal  output  1  registered with done, 1 when opcode was unsupported

Behaviour:
- Reset (rst=1 at a clk edge):
  - result=0, zero=1, done=0, busy=0, illegal=0; state IDLE.
  - Reset overrides everything, including mid-operation; a partial result is discarded.
- States: IDLE, RUN.
- Accept: when start=1 in IDLE at edge E0, latch opcode, operandA, operandB.
- Opcodes:
  - 0 ADD
  - 1 SUB
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: signed two's complement, result 1 or 0
  - 6 SLL by operandB[4:0]
  - 7 SRL, logical, by operandB[4:0]
  - 8 MUL: low WIDTH bits of the unsigned product
  - 9-15 illegal
- Single-cycle ops (0-5, illegal, and shifts with amount 0):
  - result, zero, illegal and done=1 are visible after E0; latency 1; state stays IDLE.
  - Illegal opcodes give result=0, illegal=1.
- Shifts with amount n, 1..31:
  - Go to RUN after E0 with busy=1.
  - One bit position per edge; result and done=1 are visible after edge E0+n.
  - busy drops to 0 in that same cycle; return to IDLE.
- MUL:
  - RUN with a shift-add over MUL_CYCLES edges: test the multiplier LSB, conditionally add the shifted multiplicand, shift.
  - result and done are visible after edge E0+32.
  - Overflow bits are discarded; ADD/SUB wrap modulo 2^WIDTH with no carry or overflow output.
- done:
  - High for exactly one cycle per accepted request.
  - 0 in all other cycles, including cycles where start is ignored.
- start while busy=1: ignored; the latched operands are unaffected and the in-flight op completes normally.
- start=1 in the done cycle: busy=0 there, so the request is accepted back-to-back. The new result appears at the earliest after the next edge.
- result, zero and illegal change only on completion or reset; they are stable during RUN.
- Operand inputs may change freely after acceptance without affecting the in-flight op.

Test Plan:
- Reset, then ADD with A=0x0000_0005, B=0x0000_FFFF (immediate path) -> one cycle later result=0x0001_0004, zero=0, done=1 for one cycle, busy never 1.
- SUB with A=7, B=7 -> result=0, zero=1 after 1 cycle.
- SLT with A=0xFFFF_FFFF, B=1 -> result=1. SRL with A=0x8000_0000, B=31 -> busy=1 for 31 cycles, result=0x0000_0001 with done 31 cycles after acceptance.
- MUL with A=0x0001_0000, B=0x0001_0003 -> done exactly 32 cycles after acceptance, result=0x0003_0000. A second start pulsed at cycle 10 with ADD 1+1 is ignored: only one done, and result is unchanged until the MUL completes.
- MUL A=12345, B=678 in progress; rst=1 at cycle 15 -> next cycle result=0, zero=1, busy=0, done=0. No done appears later. A fresh ADD 2+3 then yields 5 after 1 cycle.
- opcode 12 -> result=0, illegal=1, done=1 after 1 cycle. Back-to-back start asserted in that done cycle with XOR 0xFF00_FF00 ^ 0x0F0F_0F0F -> result 0xF00F_F00F, illegal=0 one cycle later.

Source files
------------

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control unit and the execute-stage ALU.
// The master drives the request; the slave (the ALU) returns result, status and handshake.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             done;
  logic             busy;
  logic             illegal;

  modport master (
    output start, opcode, operandA, operandB,
    input  result, zero, done, busy, illegal
  );

  modport slave (
    input  start, opcode, operandA, operandB,
    output result, zero, done, busy, illegal
  );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: logic/arithmetic ops complete in one cycle, shifts walk one bit per
// cycle and MUL runs a shift-add loop; start/busy/done lets the control unit stall.
module multicycle_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_alu_if.slave      bus
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    K_SLL,
    K_SRL,
    K_MUL
  } kind_t;

  state_t           state_reg, state_next;
  kind_t            kind_reg, kind_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             done_reg, done_next;
  logic             illegal_reg, illegal_next;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_value;
  logic             alu_illegal;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] step_value;

  assign shamt = bus.operandB[SW-1:0];

  // Single-cycle datapath; shifts here only matter for an amount of zero.
  always_comb begin
    alu_value   = '0;
    alu_illegal = 1'b0;
    case (bus.opcode)
      OP_ADD:  alu_value = bus.operandA + bus.operandB;
      OP_SUB:  alu_value = bus.operandA - bus.operandB;
      OP_AND:  alu_value = bus.operandA & bus.operandB;
      OP_OR:   alu_value = bus.operandA | bus.operandB;
      OP_XOR:  alu_value = bus.operandA ^ bus.operandB;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.operandA) < $signed(bus.operandB))};
      OP_SLL:  alu_value = bus.operandA << shamt;
      OP_SRL:  alu_value = bus.operandA >> shamt;
      OP_MUL:  alu_value = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

  // Multiplicand gated by the current multiplier LSB forms this iteration's partial product.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  always_comb begin
    step_value = acc_reg + addend;
    case (kind_reg)
      K_SLL:   step_value = acc_reg << 1;
      K_SRL:   step_value = acc_reg >> 1;
      default: step_value = acc_reg + addend;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    kind_next    = kind_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    count_next   = count_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if ((bus.opcode == OP_SLL || bus.opcode == OP_SRL) && shamt != '0) begin
            state_next = RUN;
            kind_next  = (bus.opcode == OP_SLL) ? K_SLL : K_SRL;
            acc_next   = bus.operandA;
            count_next = CW'(shamt);
          end else if (bus.opcode == OP_MUL) begin
            state_next  = RUN;
            kind_next   = K_MUL;
            acc_next    = '0;
            mcand_next  = bus.operandA;
            mplier_next = bus.operandB;
            count_next  = CW'(MUL_CYCLES);
          end else begin
            result_next  = alu_value;
            zero_next    = (alu_value == '0);
            illegal_next = alu_illegal;
            done_next    = 1'b1;
          end
        end
      end
      RUN: begin
        acc_next    = step_value;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg - CW'(1);
        // The last iteration writes its step straight into the result register.
        if (count_reg == CW'(1)) begin
          state_next   = IDLE;
          result_next  = step_value;
          zero_next    = (step_value == '0);
          illegal_next = 1'b0;
          done_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      kind_reg    <= K_SLL;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      kind_reg    <= kind_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      count_reg   <= count_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      done_reg    <= done_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.result  = result_reg;
  assign bus.zero    = zero_reg;
  assign bus.done    = done_reg;
  assign bus.illegal = illegal_reg;
  assign bus.busy    = (state_reg == RUN);

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios plus randomized ops checked
// against a plain-arithmetic reference model.
module tb_multicycle_alu;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(WIDTH)) bus ();

  multicycle_alu #(.WIDTH(WIDTH), .MUL_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_result;

  // Reference: result, illegal flag, and number of edges after acceptance before done.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int edges);
    logic [63:0] p;
    int n;
    n     = int'(b[4:0]);
    ill   = 1'b0;
    edges = 0;
    r     = 32'd0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: begin r = a << n; edges = n; end
      4'd7: begin r = a >> n; edges = n; end
      4'd8: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; edges = 32; end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cnt, output int unstable,
                        output logic busy_at_done, output logic [31:0] res,
                        output logic zr, output logic ill);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operandA = a; bus.operandB = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.opcode = 4'($urandom); bus.operandA = $urandom; bus.operandB = $urandom;
    edges = 0; busy_cnt = 0; unstable = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.result !== last_result) unstable++;
      @(posedge clk); #1;
      edges++;
    end
    busy_at_done = bus.busy;
    res = bus.result; zr = bus.zero; ill = bus.illegal;
    $display("op=%0d a=%h b=%h -> result=%h zero=%b illegal=%b edges=%0d busy_cycles=%0d",
             op, a, b, res, zr, ill, edges, busy_cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.opcode = 4'd0; bus.operandA = '0; bus.operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got result=%h zero=%b done=%b busy=%b illegal=%b, want 0/1/0/0/0",
               bus.result, bus.zero, bus.done, bus.busy, bus.illegal);
    end
    @(negedge clk); rst = 1'b0;
    last_result = 32'd0;
  endtask

  task automatic test_add_imm;
    int e, bc, un; logic bd, z, il; logic [31:0] r;
    run_op(4'd0, 32'h0000_0005, 32'h0000_FFFF, e, bc, un, bd, r, z, il);
    vectors++;
    if (r !== 32'h0001_0004 || z !== 1'b0 || e !== 0 || bc !== 0 || bd !== 1'b0) begin
      miscompares++;
      $display("FAIL add_imm: got result=%h zero=%b edges=%0d busy=%0d, want 00010004/0/0/0", r, z, e, bc);
    end
    last_result = 32'h0001_0004;
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.result !== 32'h0001_0004) begin
      miscompares++;
      $display("FAIL add_done_pulse: got done=%b result=%h, want 0/00010004", bus.done, bus.result);
    end
  endtask

  task automatic test_sub_zero;
    int e, bc, un; logic bd, z, il; logic [31:0] r;
    run_op(4'd1, 32'd7, 32'd7, e, bc, un, bd, r, z, il);
    vectors++;
    if (r !== 32'd0 || z !== 1'b1 || e !== 0) begin
      miscompares++;
      $display("FAIL sub_zero: got result=%h zero=%b edges=%0d, want 0/1/0", r, z, e);
    end
    last_result = 32'd0;
  endtask

  task automatic test_slt_srl;
    int e, bc, un; logic bd, z, il; logic [31:0] r;
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, e, bc, un, bd, r, z, il);
    vectors++;
    if (r !== 32'd1 || z !== 1'b0 || e !== 0) begin
      miscompares++;
      $display("FAIL slt_signed: got result=%h edges=%0d, want 1/0", r, e);
    end
    last_result = 32'd1;
    run_op(4'd7, 32'h8000_0000, 32'd31, e, bc, un, bd, r, z, il);
    vectors++;
    if (r !== 32'd1 || e !== 31 || bc !== 31 || bd !== 1'b0 || un !== 0) begin
      miscompares++;
      $display("FAIL srl_31: got result=%h edges=%0d busy=%0d busy_at_done=%b unstable=%0d, want 1/31/31/0/0",
               r, e, bc, bd, un);
    end
    last_result = 32'd1;
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL srl_tail: got done=%b busy=%b, want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_mul_ignore;
    int dones = 0; int first = -1; int un = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 4'd8; bus.operandA = 32'h0001_0000; bus.operandB = 32'h0001_0003;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.operandA = $urandom; bus.operandB = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) begin
        bus.start = 1'b1; bus.opcode = 4'd0; bus.operandA = 32'd1; bus.operandB = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end else if (first < 0 && bus.result !== last_result) begin
        un++;
      end
      if (k == 32) begin
        vectors++;
        if (bus.result !== 32'h0003_0000 || bus.done !== 1'b1) begin
          miscompares++;
          $display("FAIL mul_result: got result=%h done=%b at edge 32, want 00030000/1", bus.result, bus.done);
        end
      end
    end
    vectors++;
    if (dones !== 1 || first !== 32 || un !== 0) begin
      miscompares++;
      $display("FAIL mul_ignore_start: got dones=%0d first_done=%0d unstable=%0d, want 1/32/0", dones, first, un);
    end
    $display("op=8 a=00010000 b=00010003 with ignored ADD -> result=%h dones=%0d", bus.result, dones);
    last_result = 32'h0003_0000;
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int e, bc, un; logic bd, z, il; logic [31:0] r;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 4'd8; bus.operandA = 32'd12345; bus.operandB = 32'd678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got result=%h zero=%b busy=%b done=%b, want 0/1/0/0",
               bus.result, bus.zero, bus.busy, bus.done);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
    end
    $display("op=8 a=%h b=%h aborted by reset -> result=%h", 32'd12345, 32'd678, bus.result);
    last_result = 32'd0;
    run_op(4'd0, 32'd2, 32'd3, e, bc, un, bd, r, z, il);
    vectors++;
    if (r !== 32'd5 || e !== 0) begin
      miscompares++;
      $display("FAIL add_after_reset: got result=%h edges=%0d, want 5/0", r, e);
    end
    last_result = 32'd5;
  endtask

  task automatic test_illegal_back_to_back;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 4'd12; bus.operandA = $urandom; bus.operandB = $urandom;
    @(posedge clk); #1;
    vectors++;
    if (bus.result !== 32'd0 || bus.illegal !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op: got result=%h illegal=%b done=%b busy=%b, want 0/1/1/0",
               bus.result, bus.illegal, bus.done, bus.busy);
    end
    $display("op=12 -> result=%h illegal=%b", bus.result, bus.illegal);
    bus.start = 1'b1; bus.opcode = 4'd4; bus.operandA = 32'hFF00_FF00; bus.operandB = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.result !== 32'hF00F_F00F || bus.illegal !== 1'b0 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back_xor: got result=%h illegal=%b done=%b, want f00ff00f/0/1",
               bus.result, bus.illegal, bus.done);
    end
    $display("op=4 a=ff00ff00 b=0f0f0f0f back-to-back -> result=%h", bus.result);
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_pulse: got done=%b, want 0", bus.done);
    end
    last_result = 32'hF00F_F00F;
  endtask

  task automatic test_random;
    int e, bc, un; logic bd, z, il; logic [31:0] r;
    logic [3:0] op; logic [31:0] a, b, er; logic eil; int ee;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ((op == 4'd6 || op == 4'd7) && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 3));
      if (op == 4'd5 && $urandom_range(0, 3) == 0) b = a;
      model(op, a, b, er, eil, ee);
      run_op(op, a, b, e, bc, un, bd, r, z, il);
      vectors++;
      if (r !== er || z !== (er == 32'd0) || il !== eil) begin
        miscompares++;
        $display("FAIL rand_value[%0d]: op=%0d got result=%h zero=%b illegal=%b, want %h/%b/%b",
                 i, op, r, z, il, er, (er == 32'd0), eil);
      end
      vectors++;
      if (e !== ee || bc !== ee || bd !== 1'b0 || un !== 0) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: op=%0d got edges=%0d busy=%0d busy_at_done=%b unstable=%0d, want %0d/%0d/0/0",
                 i, op, e, bc, bd, un, ee, ee);
      end
      last_result = er;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    last_result = 32'd0;
    test_reset();
    test_add_imm();
    test_sub_zero();
    test_slt_srl();
    test_mul_ignore();
    test_reset_mid();
    test_illegal_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
